// File: rtl/life_pkg.sv
// Shared types and grid geometry for the Game of Life generation sequencer.
package life_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned GEN_W = 16;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SCAN,
    S_STEP
  } seq_state_t;

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] row);
    return (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
  endfunction

endpackage

// File: rtl/life_gen_sequencer_if.sv
// Bus between the generation sequencer (master) and the cell array / display side (slave).
interface life_gen_sequencer_if;
  import life_pkg::*;

  logic             run_en;
  logic             single_step;
  logic             load_req;
  logic [COLS-1:0]  row_data;
  logic             step_ack;
  logic [ROW_W-1:0] row_sel;
  logic [COLS-1:0]  leds_out;
  logic             frame_start;
  logic             load_en;
  logic             step_req;
  logic [GEN_W-1:0] gen_count;
  logic             step_err;

  modport master (
    input  run_en, single_step, load_req, row_data, step_ack,
    output row_sel, leds_out, frame_start, load_en, step_req, gen_count, step_err
  );

  modport slave (
    output run_en, single_step, load_req, row_data, step_ack,
    input  row_sel, leds_out, frame_start, load_en, step_req, gen_count, step_err
  );

endinterface

// File: rtl/life_row_scanner.sv
// Row/frame counters and the registered LED row; parks on row 0 with the display frozen while held.
module life_row_scanner
  import life_pkg::*;
#(
  parameter int unsigned FRAMES_PER_GEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic [COLS-1:0]  i_row_data,
  output logic [ROW_W-1:0] o_row_sel,
  output logic [COLS-1:0]  o_leds_out,
  output logic             o_frame_start,
  output logic             o_frame_wrap
);

  localparam int unsigned FRM_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  logic [ROW_W-1:0] r_row;
  logic [COLS-1:0]  r_leds;
  logic [FRM_W-1:0] r_frame_cnt;
  logic             w_row_last;
  logic             w_frame_last;

  assign w_row_last   = (r_row == ROW_W'(ROWS - 1));
  assign w_frame_last = (r_frame_cnt == FRM_W'(FRAMES_PER_GEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row       <= '0;
      r_leds      <= '0;
      r_frame_cnt <= '0;
    end else if (i_hold) begin
      r_row <= '0;
    end else begin
      r_row  <= row_inc(r_row);
      r_leds <= i_row_data;
      if (w_row_last) begin
        r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + 1'b1;
      end
    end
  end

  assign o_row_sel     = r_row;
  assign o_leds_out    = r_leds;
  assign o_frame_start = !i_hold && (r_row == '0);
  // Asserted on the last row of the last frame before a generation boundary.
  assign o_frame_wrap  = !i_hold && w_row_last && w_frame_last;

endmodule

// File: rtl/life_gen_sequencer.sv
// Game of Life controller: time-shares the grid between row scanning and generation steps.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int unsigned FRAMES_PER_GEN = 1,
  parameter int unsigned STEP_TIMEOUT   = 16
) (
  input logic                  clk,
  input logic                  rst,
  life_gen_sequencer_if.master bus
);

  localparam int unsigned TMO_W = $clog2(STEP_TIMEOUT + 1);

  seq_state_t       r_state;
  logic             r_load_en;
  logic             r_step_req;
  logic             r_step_err;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_pend_step;
  logic             r_pend_load;
  logic [TMO_W-1:0] r_tmo_cnt;

  logic             w_hold;
  logic             w_frame_wrap;
  logic             w_ack_taken;
  logic [ROW_W-1:0] w_row_sel;
  logic [COLS-1:0]  w_leds_out;
  logic             w_frame_start;

  assign w_hold      = (r_state != S_SCAN);
  assign w_ack_taken = (r_state == S_STEP) && bus.step_ack;

  life_row_scanner #(
    .FRAMES_PER_GEN (FRAMES_PER_GEN)
  ) u_scanner (
    .clk           (clk),
    .rst           (rst),
    .i_hold        (w_hold),
    .i_row_data    (bus.row_data),
    .o_row_sel     (w_row_sel),
    .o_leds_out    (w_leds_out),
    .o_frame_start (w_frame_start),
    .o_frame_wrap  (w_frame_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_LOAD;
      r_load_en   <= 1'b0;
      r_step_req  <= 1'b0;
      r_step_err  <= 1'b0;
      r_gen_count <= '0;
      r_pend_step <= 1'b0;
      r_pend_load <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_load_en <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          r_load_en   <= 1'b1;
          r_gen_count <= '0;
          r_state     <= S_SCAN;
        end
        S_SCAN: begin
          if (w_frame_wrap) begin
            if (r_pend_load) begin
              r_state <= S_LOAD;
            end else if (bus.run_en || r_pend_step) begin
              r_state    <= S_STEP;
              r_step_req <= 1'b1;
              r_tmo_cnt  <= '0;
            end
          end
        end
        S_STEP: begin
          if (bus.step_ack) begin
            r_step_req  <= 1'b0;
            r_gen_count <= r_gen_count + 1'b1;
            r_state     <= r_pend_load ? S_LOAD : S_SCAN;
          end else if (r_tmo_cnt == TMO_W'(STEP_TIMEOUT - 1)) begin
            // Give up on this generation; the display keeps running.
            r_step_req <= 1'b0;
            r_step_err <= 1'b1;
            r_state    <= S_SCAN;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase

      // A fresh request arriving alongside its consumption stays pending.
      r_pend_step <= bus.single_step || (r_pend_step && !w_ack_taken);
      r_pend_load <= bus.load_req || (r_pend_load && (r_state != S_LOAD));
    end
  end

  assign bus.row_sel     = w_row_sel;
  assign bus.leds_out    = w_leds_out;
  assign bus.frame_start = w_frame_start;
  assign bus.load_en     = r_load_en;
  assign bus.step_req    = r_step_req;
  assign bus.gen_count   = r_gen_count;
  assign bus.step_err    = r_step_err;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer with a simple delayed-ack cell array model.
module tb_life_gen_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  life_gen_sequencer_if u_if ();

  life_gen_sequencer #(
    .FRAMES_PER_GEN (1),
    .STEP_TIMEOUT   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int ack_delay = 3;
  int ack_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the DUT just out of reset, in LOAD, at a falling edge (t=0).
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Cell array: acks once step_req has been seen high for ack_delay cycles; 0 = never.
  initial begin
    u_if.step_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.step_req === 1'b1) ack_cnt++;
      else ack_cnt = 0;
      u_if.step_ack = (ack_delay != 0) && (ack_cnt == ack_delay + 1);
    end
  end

  initial begin
    int sr_n;
    int ld_n;
    int fs_n;
    int fs_last;
    int fs_prev;

    u_if.run_en      = 1'b0;
    u_if.single_step = 1'b0;
    u_if.load_req    = 1'b0;
    u_if.row_data    = 8'hA5;

    // Idle scanning after reset
    ack_delay = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_row_sel", u_if.row_sel, 0);
    check_eq("rst_leds", u_if.leds_out, 0);
    check_eq("rst_load_en", u_if.load_en, 0);
    check_eq("rst_step_req", u_if.step_req, 0);
    check_eq("rst_gen", u_if.gen_count, 0);
    check_eq("rst_err", u_if.step_err, 0);
    rst = 1'b1;
    cyc(1);
    check_eq("t1_load_en", u_if.load_en, 1);
    check_eq("t1_row", u_if.row_sel, 0);
    check_eq("t1_frame_start", u_if.frame_start, 1);
    check_eq("t1_leds", u_if.leds_out, 0);
    cyc(1);
    check_eq("t2_load_en", u_if.load_en, 0);
    check_eq("t2_row", u_if.row_sel, 1);
    check_eq("t2_leds", u_if.leds_out, 8'hA5);
    check_eq("t2_frame_start", u_if.frame_start, 0);
    sr_n = 0;
    ld_n = 0;
    for (int t = 3; t <= 20; t++) begin
      cyc(1);
      check_eq("idle_row", u_if.row_sel, (t - 1) % 8);
      if (u_if.step_req) sr_n++;
      if (u_if.load_en) ld_n++;
    end
    check_eq("idle_no_step", sr_n, 0);
    check_eq("idle_no_load", ld_n, 0);
    check_eq("idle_gen", u_if.gen_count, 0);

    // Free run, ack after 3 cycles: 12-cycle frame period
    ack_delay = 3;
    u_if.run_en = 1'b1;
    do_reset();
    sr_n = 0;
    fs_n = 0;
    fs_last = 0;
    fs_prev = 0;
    for (int t = 1; t <= 61; t++) begin
      cyc(1);
      if (u_if.frame_start) begin
        fs_n++;
        fs_prev = fs_last;
        fs_last = t;
      end
      if (u_if.step_req) sr_n++;
      if (t == 8) check_eq("run_req_before", u_if.step_req, 0);
      if (t == 9) check_eq("run_req_rise", u_if.step_req, 1);
      if (t == 9) check_eq("run_row_held", u_if.row_sel, 0);
      if (t == 13) check_eq("run_req_drop", u_if.step_req, 0);
      if (t == 13) check_eq("run_gen1", u_if.gen_count, 1);
    end
    check_eq("run_frames", fs_n, 6);
    check_eq("run_period", fs_last - fs_prev, 12);
    check_eq("run_req_cycles", sr_n, 20);
    check_eq("run_gen5", u_if.gen_count, 5);

    // Two single_step pulses collapse into one step
    u_if.run_en = 1'b0;
    do_reset();
    sr_n = 0;
    for (int t = 1; t <= 40; t++) begin
      cyc(1);
      if (u_if.step_req) sr_n++;
      if (t == 8) check_eq("ss_req_before", u_if.step_req, 0);
      if (t == 9) check_eq("ss_req_rise", u_if.step_req, 1);
      u_if.single_step = (t == 3) || (t == 5);
    end
    check_eq("ss_req_cycles", sr_n, 4);
    check_eq("ss_gen", u_if.gen_count, 1);

    // load_req during STEP: step completes, then reload
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      cyc(1);
      if (t == 12) check_eq("ld_step_busy", u_if.step_req, 1);
      if (t == 13) check_eq("ld_gen_after_step", u_if.gen_count, 1);
      if (t == 13) check_eq("ld_req_dropped", u_if.step_req, 0);
      if (t == 13) check_eq("ld_en_not_yet", u_if.load_en, 0);
      if (t == 14) check_eq("ld_en_pulse", u_if.load_en, 1);
      if (t == 14) check_eq("ld_gen_cleared", u_if.gen_count, 0);
      if (t == 14) check_eq("ld_row0", u_if.row_sel, 0);
      if (t == 15) check_eq("ld_en_single", u_if.load_en, 0);
      if (t == 15) check_eq("ld_row1", u_if.row_sel, 1);
      u_if.single_step = (t == 2);
      u_if.load_req    = (t == 10);
    end

    // No ack: timeout after 16 cycles, sticky error
    ack_delay = 0;
    u_if.run_en = 1'b1;
    do_reset();
    sr_n = 0;
    for (int t = 1; t <= 40; t++) begin
      cyc(1);
      if (u_if.step_req) sr_n++;
      if (t == 24) check_eq("to_req_last", u_if.step_req, 1);
      if (t == 24) check_eq("to_err_before", u_if.step_err, 0);
      if (t == 25) check_eq("to_req_drop", u_if.step_req, 0);
      if (t == 25) check_eq("to_err_set", u_if.step_err, 1);
      if (t == 25) check_eq("to_row0", u_if.row_sel, 0);
      if (t == 26) check_eq("to_row1", u_if.row_sel, 1);
      if (t == 25) u_if.run_en = 1'b0;
    end
    check_eq("to_req_cycles", sr_n, 16);
    check_eq("to_err_sticky", u_if.step_err, 1);
    check_eq("to_gen", u_if.gen_count, 0);

    // Async reset while a step is in flight
    ack_delay = 3;
    u_if.run_en = 1'b1;
    do_reset();
    cyc(22);
    check_eq("ar_req_busy", u_if.step_req, 1);
    check_eq("ar_gen_before", u_if.gen_count, 1);
    check_eq("ar_leds_before", u_if.leds_out, 8'hA5);
    rst = 1'b0;
    #1;
    check_eq("ar_req_async", u_if.step_req, 0);
    check_eq("ar_gen_async", u_if.gen_count, 0);
    check_eq("ar_leds_async", u_if.leds_out, 0);
    check_eq("ar_err_async", u_if.step_err, 0);
    @(negedge clk);
    rst = 1'b1;
    u_if.run_en = 1'b0;
    cyc(1);
    check_eq("ar_load_again", u_if.load_en, 1);
    cyc(1);
    check_eq("ar_load_single", u_if.load_en, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Controller for the 8x8 Game of Life datapath.
- Owns the shared cell grid. Time-shares it between LED row scanning (read one row per cycle) and generation update (step handshake to the cell array).
- Handles seed load, free-run and single-step.
- Sits between the cell array and the leds_out pins inside main.

Parameters:
- ROWS, 8, grid rows; one row scanned per cycle.
- COLS, 8, grid columns; width of row_data and leds_out.
- FRAMES_PER_GEN, 1, full display frames shown between generation steps (>=1).
- STEP_TIMEOUT, 16, max cycles to wait for step_ack before flagging an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- run_en  input  1  level; 1 = step automatically every FRAMES_PER_GEN frames.
- single_step  input  1  one-cycle pulse; request exactly one generation step.
- load_req  input  1  one-cycle pulse; reload seed pattern into grid.
- row_data  input  COLS  grid contents of row addressed by row_sel (combinational from array).
- step_ack  input  1  cell array finished computing next generation.
- row_sel  output  $clog2(ROWS)  row address to grid.
- leds_out  output  COLS  registered display row.
- frame_start  output  1  pulse while row_sel==0 in SCAN.
- load_en  output  1  one-cycle strobe: array loads seed.
- step_req  output  1  held high until step_ack.
- gen_count  output  16  generations completed since last load.
- step_err  output  1  sticky; step_ack timeout occurred.

Behaviour:
- Reset (rst low, async): state=LOAD, row_sel=0, leds_out=0, frame_start=0, load_en=0, step_req=0, gen_count=0, step_err=0, frame_cnt=0, pending flags cleared.
- States: LOAD, SCAN, STEP.
- LOAD:
  - load_en=1 for exactly one cycle; gen_count<=0; pending_load cleared.
  - Next cycle: SCAN with row_sel=0.
- SCAN:
  - row_sel increments by 1 each cycle, wrapping ROWS-1 -> 0.
  - leds_out <= row_data every cycle, so leds_out at cycle t+1 shows row row_sel(t).
  - frame_start = (row_sel==0).
- Frame end: in the cycle row_sel==ROWS-1, frame_cnt increments, wrapping at FRAMES_PER_GEN. At wrap:
  - If pending_load: go to LOAD.
  - Else if run_en or pending_step: go to STEP, row_sel<=0.
  - Else: continue SCAN.
- STEP:
  - step_req=1; row_sel held 0; leds_out holds.
  - On step_ack high: step_req drops the next cycle, gen_count+1 (wraps at 2^16), pending_step cleared.
  - Following state: LOAD if pending_load, else SCAN.
  - If STEP_TIMEOUT cycles elapse without ack: step_err<=1 (sticky until reset), step_req<=0, return to SCAN, gen_count unchanged.
- pending_step: set by single_step in any state; multiple pulses before consumption collapse to one. Also cleared when a run_en step completes.
- pending_load: set by load_req in any state; never aborts a STEP in flight. Load beats step at the same boundary; pending_step survives.
- step_ack outside STEP is ignored.
- run_en dropping mid-STEP does not cancel the step.
- Reset mid-STEP: step_req drops asynchronously.

Decomposition:
- Package life_pkg holds:
  - typedef enum seq_state_t {S_LOAD, S_SCAN, S_STEP};
  - constants ROWS=8, COLS=8, ROW_W=$clog2(ROWS).
- One sub-module, life_row_scanner: row counter, frame counter, frame_start, leds_out register, with a hold input driven from STEP.
- FSM, pending flags, timeout counter and gen_count live in life_gen_sequencer.

Test Plan:
- Reset release with run_en=0, step_ack tied 0, row_data=8'hA5 -> load_en pulses once on the first cycle, then row_sel cycles 0..7 repeatedly; leds_out=8'hA5 one cycle after first SCAN cycle; step_req never asserts; gen_count stays 0.
- run_en=1, FRAMES_PER_GEN=1, array model acks 3 cycles after step_req -> step_req rises after each row 7; gen_count reaches 5 after 5 frames; frame_start period = 8+4 cycles.
- run_en=0, two single_step pulses 2 cycles apart mid-frame -> exactly one step at next frame end; gen_count=1; no further step.
- load_req pulsed during STEP -> step completes (gen_count=1), then LOAD: load_en high one cycle, gen_count=0.
- Array never acks, STEP_TIMEOUT=16 -> step_req high exactly 16 cycles, then step_err=1 sticky, scanning resumes at row 0, gen_count=0.
- rst asserted while step_req=1 -> step_req, leds_out, gen_count go 0 immediately; after release, LOAD strobe repeats.
